id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline. Sits between the IF/ID register and the ID/EX register and produces every input that the ID/EX register captures.
- Contains the 32x32 register file (written from WB), the control decoder, immediate generation and load-use hazard detection.
- Drives stall to IF and IF/ID. Inserts a bubble into ID/EX on a stall or a flush.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register count; index width is $clog2(NREGS).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- instr_in  in  32  instruction from IF/ID
- pc_in  in  32  PC from IF/ID
- valid_in  in  1  IF/ID holds a real instruction
- flush  in  1  branch/jump taken in EX; kill the current decode
- ex_mem_read  in  1  mem_read of the instruction now in ID/EX
- ex_rd  in  5  rd of the instruction now in ID/EX
- wb_reg_write  in  1  WB write enable
- wb_rd  in  5  WB destination
- wb_data  in  32  WB write data
- imm_out, rd_1_out, rd_2_out, pc_out  out  32 each  to ID/EX
- reg_write_out, is_imm_out, mem_read_out, mem_write_out, mem_to_reg_out, jump_out, branch_out, U_type_out  out  1 each  controls
- alu_op_out  out  3  ALU class
- funct3_out  out  3
- funct7b5_out  out  1
- rd_out  out  5
- op_out  out  7
- stall  out  1  hold the PC and IF/ID this cycle
- illegal_sticky  out  1  latched illegal-opcode flag

Behaviour:
- Register file:
  - rst low at a clock edge clears all 32 registers to 0 and clears illegal_sticky.
  - Write at the posedge when wb_reg_write=1 and wb_rd!=0.
  - x0 always reads 0.
  - Reads are combinational, from rs1=instr[19:15] and rs2=instr[24:20].
  - Same-cycle bypass: if wb_reg_write=1, wb_rd!=0 and wb_rd==rsN, rd_N_out=wb_data.
- Decode is combinational. Latency from instr_in to the outputs is 0 cycles; ID/EX provides the register.
- op_out=instr[6:0], rd_out=instr[11:7], funct3_out=instr[14:12], funct7b5_out=instr[30], pc_out=pc_in.
- alu_op encoding: 000 load/store address, 001 branch compare, 010 R-type, 011 I-type ALU, 100 LUI, 101 AUIPC, 110 JAL/JALR, 111 none.
- Immediates are sign-extended to XLEN:
  - I-type: loads, OP-IMM, JALR.
  - S-type: stores.
  - B-type: branches, bit0=0.
  - U-type: {instr[31:12],12'b0}.
  - J-type: JAL, bit0=0.
  - R-type: imm_out=0.
- Control per opcode:
  - R: reg_write.
  - OP-IMM: reg_write, is_imm.
  - LOAD: reg_write, is_imm, mem_read, mem_to_reg.
  - STORE: is_imm, mem_write.
  - BRANCH: branch.
  - JAL: reg_write, jump.
  - JALR: reg_write, jump, is_imm.
  - LUI and AUIPC: reg_write, U_type.
- Illegal opcode:
  - All controls are 0 and alu_op=111.
  - If valid_in=1 and flush=0, illegal_sticky sets at the next edge and holds until reset.
- Load-use hazard:
  - rs1 is used by every format except U and J. rs2 is used only by R, S and B.
  - stall=1 when valid_in=1, ex_mem_read=1, ex_rd!=0, and ex_rd equals a used rs.
  - Otherwise stall=0.
- Bubble: if stall, flush, valid_in=0 or rst=0, all control outputs are 0 and alu_op=111.
  - Data fields still pass through unchanged.
- Flush has priority over stall: when flush=1, stall=0.
- While rst=0:
  - stall=0.
  - Controls are bubbled.
  - rd_1_out and rd_2_out read 0 from the cleared regfile; the bypass is suppressed.
- Reset mid-operation: the regfile is cleared at the next edge regardless of wb_reg_write.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams: OP_R=0110011, OP_IMM=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111, OP_JALR=1100111, OP_LUI=0110111, OP_AUIPC=0010111.
  - the alu_op_t enum.
  - the imm_fmt_t enum (I,S,B,U,J,NONE).
- One sub-module, regfile, containing storage, the write port, two read ports and the WB bypass. Decode, immediate generation and hazard logic stay in id_stage.

Test Plan:
- Reset then write: hold rst=0 for 2 clocks, release, then write x5=32'hDEADBEEF via WB. Decode "add x1,x5,x0" (32'h000280B3) -> rd_1_out=DEADBEEF, rd_2_out=0, reg_write=1, alu_op=010, rd_out=1.
- Bypass and x0: wb_rd=6, wb_data=32'h12345678 in the same cycle as "addi x2,x6,-1" (32'hFFF30113) -> rd_1_out=12345678, imm_out=FFFFFFFF, is_imm=1. A WB to x0 followed by reading x0 -> 0.
- Load-use: ex_mem_read=1, ex_rd=3, decode "sw x3,8(x4)" (32'h00322423) -> stall=1, all controls 0. Then ex_rd=7 -> stall=0, mem_write=1, imm_out=8.
- Flush beats stall: same hazard as above with flush=1 -> stall=0 and controls bubbled. Also "beq x1,x2,-4" (32'hFE208EE3) with flush=0 -> branch=1, imm_out=FFFFFFFC, alu_op=001.
- U/J formats: "lui x9,0xABCDE" (32'hABCDE4B7) -> imm_out=ABCDE000, U_type=1, alu_op=100. "jal x1,+16" (32'h010000EF) -> jump=1, imm_out=16.
- Illegal opcode: instr=32'hFFFFFFFF with valid_in=1 -> controls 0 and illegal_sticky=1 from the next edge. It stays 1 until rst=0 at an edge clears it.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU class, immediate formats and
// the control bundle carried into ID/EX.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    AluMem    = 3'b000,
    AluBranch = 3'b001,
    AluR      = 3'b010,
    AluI      = 3'b011,
    AluLui    = 3'b100,
    AluAuipc  = 3'b101,
    AluJump   = 3'b110,
    AluNone   = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ,
    ImmNone
  } imm_fmt_t;

  typedef struct packed {
    logic reg_write;
    logic is_imm;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic jump;
    logic branch;
    logic u_type;
  } ctrl_t;

endpackage

// File: rtl/regfile.sv
// Integer register file: synchronous active-low clear, one write port from WB,
// two combinational read ports with same-cycle WB bypass. x0 reads as zero.
module regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads are forced to zero during reset so the bypass cannot leak WB data.
  always_comb begin
    rdata1_o = '0;
    if (rst_ni && (raddr1_i != '0)) begin
      rdata1_o = (wr_en && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (rst_ni && (raddr2_i != '0)) begin
      rdata2_o = (wr_en && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, control decode, immediate generation,
// load-use stall and bubble insertion feeding the ID/EX register.
module id_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [31:0]     pc_in,
  input  logic            valid_in,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] rd_1_out,
  output logic [XLEN-1:0] rd_2_out,
  output logic [31:0]     pc_out,
  output logic            reg_write_out,
  output logic            is_imm_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            mem_to_reg_out,
  output logic            jump_out,
  output logic            branch_out,
  output logic            U_type_out,
  output logic [2:0]      alu_op_out,
  output logic [2:0]      funct3_out,
  output logic            funct7b5_out,
  output logic [4:0]      rd_out,
  output logic [6:0]      op_out,
  output logic            stall,
  output logic            illegal_sticky
);

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2;
  imm_fmt_t    imm_fmt;
  alu_op_t     alu_sel;
  ctrl_t       ctrl_dec, ctrl_out;
  logic        use_rs1, use_rs2, illegal;
  logic        hazard, bubble;
  logic [31:0] imm32;
  logic        illegal_sticky_d, illegal_sticky_q;

  assign opcode = instr_in[6:0];
  assign rs1    = instr_in[19:15];
  assign rs2    = instr_in[24:20];

  regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (wb_reg_write),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rd_1_out),
    .rdata2_o (rd_2_out)
  );

  always_comb begin
    imm_fmt  = ImmNone;
    alu_sel  = AluNone;
    ctrl_dec = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        alu_sel            = AluR;
        ctrl_dec.reg_write = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      OP_IMM: begin
        imm_fmt            = ImmI;
        alu_sel            = AluI;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.is_imm    = 1'b1;
        use_rs1            = 1'b1;
      end
      OP_LOAD: begin
        imm_fmt             = ImmI;
        alu_sel             = AluMem;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.is_imm     = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        use_rs1             = 1'b1;
      end
      OP_STORE: begin
        imm_fmt            = ImmS;
        alu_sel            = AluMem;
        ctrl_dec.is_imm    = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      OP_BRANCH: begin
        imm_fmt         = ImmB;
        alu_sel         = AluBranch;
        ctrl_dec.branch = 1'b1;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
      end
      OP_JAL: begin
        imm_fmt            = ImmJ;
        alu_sel            = AluJump;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.jump      = 1'b1;
      end
      OP_JALR: begin
        imm_fmt            = ImmI;
        alu_sel            = AluJump;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.jump      = 1'b1;
        ctrl_dec.is_imm    = 1'b1;
        use_rs1            = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_fmt            = ImmU;
        alu_sel            = (opcode == OP_LUI) ? AluLui : AluAuipc;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.u_type    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_fmt)
      ImmI:    imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      ImmS:    imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      ImmB:    imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                        instr_in[11:8], 1'b0};
      ImmU:    imm32 = {instr_in[31:12], 12'b0};
      ImmJ:    imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                        instr_in[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_out = XLEN'($signed(imm32));

  // Only operands the instruction actually reads can create a load-use hazard.
  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
  assign stall  = rst && valid_in && !flush && hazard;
  assign bubble = stall || flush || !valid_in || !rst;

  assign ctrl_out       = bubble ? '0 : ctrl_dec;
  assign reg_write_out  = ctrl_out.reg_write;
  assign is_imm_out     = ctrl_out.is_imm;
  assign mem_read_out   = ctrl_out.mem_read;
  assign mem_write_out  = ctrl_out.mem_write;
  assign mem_to_reg_out = ctrl_out.mem_to_reg;
  assign jump_out       = ctrl_out.jump;
  assign branch_out     = ctrl_out.branch;
  assign U_type_out     = ctrl_out.u_type;
  assign alu_op_out     = bubble ? AluNone : alu_sel;

  assign op_out       = opcode;
  assign rd_out       = instr_in[11:7];
  assign funct3_out   = instr_in[14:12];
  assign funct7b5_out = instr_in[30];
  assign pc_out       = pc_in;

  always_comb begin
    illegal_sticky_d = illegal_sticky_q;
    if (illegal && valid_in && !flush) illegal_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal_sticky_q <= 1'b0;
    end else begin
      illegal_sticky_q <= illegal_sticky_d;
    end
  end

  assign illegal_sticky = illegal_sticky_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, regfile write/bypass, decode formats,
// load-use stall, flush priority and the sticky illegal-opcode flag.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, pc_in;
  logic        valid_in, flush, ex_mem_read, wb_reg_write;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] wb_data;
  logic [31:0] imm_out, rd_1_out, rd_2_out, pc_out;
  logic        reg_write_out, is_imm_out, mem_read_out, mem_write_out, mem_to_reg_out;
  logic        jump_out, branch_out, U_type_out;
  logic [2:0]  alu_op_out, funct3_out;
  logic        funct7b5_out;
  logic [4:0]  rd_out;
  logic [6:0]  op_out;
  logic        stall, illegal_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .instr_in       (instr_in),
    .pc_in          (pc_in),
    .valid_in       (valid_in),
    .flush          (flush),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .imm_out        (imm_out),
    .rd_1_out       (rd_1_out),
    .rd_2_out       (rd_2_out),
    .pc_out         (pc_out),
    .reg_write_out  (reg_write_out),
    .is_imm_out     (is_imm_out),
    .mem_read_out   (mem_read_out),
    .mem_write_out  (mem_write_out),
    .mem_to_reg_out (mem_to_reg_out),
    .jump_out       (jump_out),
    .branch_out     (branch_out),
    .U_type_out     (U_type_out),
    .alu_op_out     (alu_op_out),
    .funct3_out     (funct3_out),
    .funct7b5_out   (funct7b5_out),
    .rd_out         (rd_out),
    .op_out         (op_out),
    .stall          (stall),
    .illegal_sticky (illegal_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Controls packed as {reg_write,is_imm,mem_read,mem_write,mem_to_reg,jump,branch,U_type}
  function automatic logic [31:0] ctrls();
    return {24'd0, reg_write_out, is_imm_out, mem_read_out, mem_write_out, mem_to_reg_out,
            jump_out, branch_out, U_type_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b0; instr_in = 32'h000280B3; pc_in = 32'h0000_0100; valid_in = 1'b1;
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE_F00D;
    tick(); tick(); settle();
    // Reset held: bubbled, no stall, bypass suppressed, sticky clear
    chk("rst_ctrls", ctrls(), 32'h0);
    chk("rst_alu", {29'd0, alu_op_out}, 32'h7);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    chk("rst_rd1_nobypass", rd_1_out, 32'h0);
    chk("rst_sticky", {31'd0, illegal_sticky}, 32'h0);
    chk("rst_pc_pass", pc_out, 32'h0000_0100);

    // Release reset; WB writes x5 at the next edge
    rst = 1'b1; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_reg_write = 1'b0; settle();
    chk("add_rd1", rd_1_out, 32'hDEAD_BEEF);
    chk("add_rd2", rd_2_out, 32'h0);
    chk("add_ctrls", ctrls(), 32'h80);
    chk("add_alu", {29'd0, alu_op_out}, 32'h2);
    chk("add_rd", {27'd0, rd_out}, 32'h1);
    chk("add_imm", imm_out, 32'h0);
    chk("add_op", {25'd0, op_out}, 32'h33);

    // Same-cycle bypass into addi x2,x6,-1
    instr_in = 32'hFFF30113; wb_reg_write = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234_5678;
    settle();
    chk("addi_bypass", rd_1_out, 32'h1234_5678);
    chk("addi_imm", imm_out, 32'hFFFF_FFFF);
    chk("addi_ctrls", ctrls(), 32'hC0);
    chk("addi_alu", {29'd0, alu_op_out}, 32'h3);
    tick();
    wb_reg_write = 1'b0; settle();
    chk("addi_stored", rd_1_out, 32'h1234_5678);

    // rs2 field of addi is 31 but unused: no stall
    ex_mem_read = 1'b1; ex_rd = 5'd31; settle();
    chk("addi_rs2_unused", {31'd0, stall}, 32'h0);
    ex_mem_read = 1'b0;

    // WB to x0 is dropped, x0 reads zero
    instr_in = 32'h00000033; wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    settle();
    chk("x0_bypass", rd_1_out, 32'h0);
    tick();
    wb_reg_write = 1'b0; settle();
    chk("x0_read", rd_1_out, 32'h0);

    // Load-use on rs2 of sw x3,8(x4)
    instr_in = 32'h00322423; ex_mem_read = 1'b1; ex_rd = 5'd3; settle();
    chk("lu_stall", {31'd0, stall}, 32'h1);
    chk("lu_ctrls", ctrls(), 32'h0);
    chk("lu_alu", {29'd0, alu_op_out}, 32'h7);
    ex_rd = 5'd7; settle();
    chk("lu_nostall", {31'd0, stall}, 32'h0);
    chk("sw_ctrls", ctrls(), 32'h50);
    chk("sw_imm", imm_out, 32'h8);
    chk("sw_alu", {29'd0, alu_op_out}, 32'h0);
    chk("sw_funct3", {29'd0, funct3_out}, 32'h2);

    // Not-valid slot never stalls and is bubbled
    ex_rd = 5'd3; valid_in = 1'b0; settle();
    chk("inv_stall", {31'd0, stall}, 32'h0);
    chk("inv_ctrls", ctrls(), 32'h0);
    valid_in = 1'b1;

    // Flush beats stall; data still passes
    flush = 1'b1; settle();
    chk("fl_stall", {31'd0, stall}, 32'h0);
    chk("fl_ctrls", ctrls(), 32'h0);
    chk("fl_alu", {29'd0, alu_op_out}, 32'h7);
    chk("fl_imm", imm_out, 32'h8);
    flush = 1'b0; ex_mem_read = 1'b0;

    // beq x1,x2,-4
    instr_in = 32'hFE208EE3; settle();
    chk("beq_ctrls", ctrls(), 32'h02);
    chk("beq_imm", imm_out, 32'hFFFF_FFFC);
    chk("beq_alu", {29'd0, alu_op_out}, 32'h1);
    chk("beq_f7b5", {31'd0, funct7b5_out}, 32'h1);

    // lui x9,0xABCDE; rs1 field (27) must not cause a stall
    instr_in = 32'hABCDE4B7; ex_mem_read = 1'b1; ex_rd = 5'd27; settle();
    chk("lui_nostall", {31'd0, stall}, 32'h0);
    chk("lui_imm", imm_out, 32'hABCD_E000);
    chk("lui_ctrls", ctrls(), 32'h81);
    chk("lui_alu", {29'd0, alu_op_out}, 32'h4);
    chk("lui_rd", {27'd0, rd_out}, 32'h9);
    ex_mem_read = 1'b0; ex_rd = 5'd0;

    // jal x1,+16
    instr_in = 32'h010000EF; settle();
    chk("jal_ctrls", ctrls(), 32'h84);
    chk("jal_imm", imm_out, 32'h10);
    chk("jal_alu", {29'd0, alu_op_out}, 32'h6);

    // Illegal opcode under flush does not latch
    instr_in = 32'hFFFF_FFFF; flush = 1'b1;
    tick(); settle();
    chk("ill_flush_nolatch", {31'd0, illegal_sticky}, 32'h0);
    flush = 1'b0; settle();
    chk("ill_ctrls", ctrls(), 32'h0);
    chk("ill_alu", {29'd0, alu_op_out}, 32'h7);
    chk("ill_not_yet", {31'd0, illegal_sticky}, 32'h0);
    tick();
    instr_in = 32'h000280B3; settle();
    chk("ill_set", {31'd0, illegal_sticky}, 32'h1);
    tick(); settle();
    chk("ill_hold", {31'd0, illegal_sticky}, 32'h1);

    // Reset clears sticky flag and regfile (x5) even with WB active
    rst = 1'b0; wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555_5555;
    tick();
    rst = 1'b1; wb_reg_write = 1'b0; settle();
    chk("ill_cleared", {31'd0, illegal_sticky}, 32'h0);
    chk("rf_cleared", rd_1_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
